// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared rv32i opcodes, branch-predictor mode encoding and a
//                helper for saturating-counter initial values.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    // Major opcodes of the control-transfer instructions
    localparam logic [6:0] c_op_br   = 7'b1100011;
    localparam logic [6:0] c_op_jal  = 7'b1101111;
    localparam logic [6:0] c_op_jalr = 7'b1100111;

    // Direction-predictor operating mode
    typedef enum logic [1:0] {
        BP_LOCAL      = 2'd0,
        BP_GSHARE     = 2'd1,
        BP_TOURNAMENT = 2'd2
    } bp_mode_e;

    // Weak value just below the taken threshold (MSB clear, all lower bits set)
    function automatic int unsigned cnt_init(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter_table.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter_table
//  Description : Table of 2**IDX_BITS saturating counters with one
//                combinational read port (returns counter MSB) and one
//                increment/decrement update port. No read/write bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter_table #(
    parameter int          IDX_BITS = 5,
    parameter int          CNT_BITS = 2,
    parameter int unsigned INIT     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic                o_rd_taken,
    input  logic                i_upd_en,
    input  logic [IDX_BITS-1:0] i_upd_idx,
    input  logic                i_upd_inc
);

    localparam int                DEPTH = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] c_init = CNT_BITS'(INIT);
    localparam logic [CNT_BITS-1:0] c_max  = '1;
    localparam logic [CNT_BITS-1:0] c_one  = CNT_BITS'(1);

    logic [CNT_BITS-1:0] r_cnt [DEPTH];
    logic [CNT_BITS-1:0] w_cur;

    assign w_cur      = r_cnt[i_upd_idx];
    assign o_rd_taken = r_cnt[i_rd_idx][CNT_BITS-1];

    // Counter storage: move toward the requested direction, clamp at the ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= c_init;
            end
        end else if (i_upd_en) begin
            if (i_upd_inc && (w_cur != c_max)) begin
                r_cnt[i_upd_idx] <= w_cur + c_one;
            end else if (!i_upd_inc && (w_cur != '0)) begin
                r_cnt[i_upd_idx] <= w_cur - c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tournament_br_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tournament_br_predictor
//  Description : IF-stage branch direction predictor. Local (bimodal), gshare
//                or tournament mode selected by MODE. Speculative GHR with
//                restore on mispredict, plus resolved/mispredict counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tournament_br_predictor
    import rv32i_types::*;
#(
    parameter int IDX_BITS = 5,
    parameter int GHR_BITS = 5,
    parameter int CNT_BITS = 2,
    parameter int MODE     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [31:0]         pc,
    input  logic [6:0]          opcode,
    output logic                predict_dir,
    output logic                predict_lc_dir,
    output logic                predict_gl_dir,
    output logic [GHR_BITS-1:0] ghr_out,
    input  logic                upd_valid,
    input  logic [6:0]          upd_opcode,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic                upd_pred_dir,
    input  logic                upd_lc_dir,
    input  logic                upd_gl_dir,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic [31:0]         total_cnt,
    output logic [31:0]         mispred_cnt
);

    localparam int unsigned c_cnt_init = cnt_init(CNT_BITS);

    logic [GHR_BITS-1:0] r_ghr;
    logic [31:0]         r_total;
    logic [31:0]         r_mispred;

    logic [IDX_BITS-1:0] w_li;
    logic [IDX_BITS-1:0] w_upd_li;
    logic                w_is_br;
    logic                w_is_jmp;
    logic                w_upd_ctrl;
    logic                w_train;
    logic                w_restore;
    logic                w_lc_dir;
    logic                w_gl_dir;
    logic                w_ch_dir;
    logic                w_base_dir;
    logic                w_unused_bits;

    assign w_li       = pc[IDX_BITS+1:2];
    assign w_upd_li   = upd_pc[IDX_BITS+1:2];
    assign w_is_br    = (opcode == c_op_br);
    assign w_is_jmp   = (opcode == c_op_jal) || (opcode == c_op_jalr);
    assign w_upd_ctrl = upd_valid && ((upd_opcode == c_op_br) ||
                                      (upd_opcode == c_op_jal) ||
                                      (upd_opcode == c_op_jalr));
    // Only conditional branches train the tables or repair the history
    assign w_train    = !stall && upd_valid && (upd_opcode == c_op_br);
    assign w_restore  = w_train && (upd_taken != upd_pred_dir);

    // Bits of the PCs above/below the index and the fields only some modes read
    assign w_unused_bits = ^{pc[31:IDX_BITS+2], pc[1:0], upd_pc[31:IDX_BITS+2],
                             upd_pc[1:0], upd_ghr[GHR_BITS-1], upd_lc_dir, upd_gl_dir};

    generate
        if (MODE != int'(BP_GSHARE)) begin : g_local
            sat_counter_table #(
                .IDX_BITS (IDX_BITS),
                .CNT_BITS (CNT_BITS),
                .INIT     (c_cnt_init)
            ) u_local (
                .clk        (clk),
                .rst        (rst),
                .i_rd_idx   (w_li),
                .o_rd_taken (w_lc_dir),
                .i_upd_en   (w_train),
                .i_upd_idx  (w_upd_li),
                .i_upd_inc  (upd_taken)
            );
        end else begin : g_no_local
            assign w_lc_dir = 1'b0;
        end

        if (MODE != int'(BP_LOCAL)) begin : g_gshare
            logic [IDX_BITS-1:0] w_gi;
            logic [IDX_BITS-1:0] w_upd_gi;
            assign w_gi     = w_li ^ IDX_BITS'(r_ghr);
            assign w_upd_gi = w_upd_li ^ IDX_BITS'(upd_ghr);
            sat_counter_table #(
                .IDX_BITS (IDX_BITS),
                .CNT_BITS (CNT_BITS),
                .INIT     (c_cnt_init)
            ) u_gshare (
                .clk        (clk),
                .rst        (rst),
                .i_rd_idx   (w_gi),
                .o_rd_taken (w_gl_dir),
                .i_upd_en   (w_train),
                .i_upd_idx  (w_upd_gi),
                .i_upd_inc  (upd_taken)
            );
        end else begin : g_no_gshare
            assign w_gl_dir = 1'b0;
        end

        if (MODE == int'(BP_TOURNAMENT)) begin : g_chooser
            // Chooser learns only when the two components disagreed
            sat_counter_table #(
                .IDX_BITS (IDX_BITS),
                .CNT_BITS (CNT_BITS),
                .INIT     (c_cnt_init)
            ) u_chooser (
                .clk        (clk),
                .rst        (rst),
                .i_rd_idx   (w_li),
                .o_rd_taken (w_ch_dir),
                .i_upd_en   (w_train && (upd_lc_dir != upd_gl_dir)),
                .i_upd_idx  (w_upd_li),
                .i_upd_inc  (upd_gl_dir == upd_taken)
            );
        end else begin : g_no_chooser
            assign w_ch_dir = 1'b0;
        end
    endgenerate

    // Final direction: jumps always taken, non-control never taken
    always_comb begin
        w_base_dir = w_lc_dir;
        if (MODE == int'(BP_GSHARE)) begin
            w_base_dir = w_gl_dir;
        end else if (MODE == int'(BP_TOURNAMENT)) begin
            w_base_dir = w_ch_dir ? w_gl_dir : w_lc_dir;
        end
        predict_dir = 1'b0;
        if (w_is_jmp) begin
            predict_dir = 1'b1;
        end else if (w_is_br) begin
            predict_dir = w_base_dir;
        end
    end

    // Global history: repair on mispredict wins over a speculative shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr <= '0;
        end else if (!stall) begin
            if (w_restore) begin
                r_ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
            end else if (w_is_br) begin
                r_ghr <= {r_ghr[GHR_BITS-2:0], predict_dir};
            end
        end
    end

    // Performance counters for resolved and mispredicted control transfers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_total   <= '0;
            r_mispred <= '0;
        end else if (!stall && w_upd_ctrl) begin
            r_total <= r_total + 32'd1;
            if (upd_taken != upd_pred_dir) begin
                r_mispred <= r_mispred + 32'd1;
            end
        end
    end

    assign predict_lc_dir = w_lc_dir;
    assign predict_gl_dir = w_gl_dir;
    assign ghr_out        = r_ghr;
    assign total_cnt      = r_total;
    assign mispred_cnt    = r_mispred;

endmodule
`default_nettype wire

// File: tb/tb_tournament_br_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tournament_br_predictor
//  Description : Directed self-checking bench. One predictor per mode
//                (0 local, 1 gshare, 2 tournament) shares the fetch and
//                resolve stimulus; the recorded fetch fields are per instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tournament_br_predictor;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic        upd_valid;
    logic [6:0]  upd_opcode;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pd [3];
    logic        upd_lc [3];
    logic        upd_gl [3];
    logic [4:0]  upd_gh [3];

    logic        pd  [3];
    logic        lc  [3];
    logic        gl  [3];
    logic [4:0]  gh  [3];
    logic [31:0] tot [3];
    logic [31:0] mis [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tournament_br_predictor #(
            .IDX_BITS (5),
            .GHR_BITS (5),
            .CNT_BITS (2),
            .MODE     (g)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .stall          (stall),
            .pc             (pc),
            .opcode         (opcode),
            .predict_dir    (pd[g]),
            .predict_lc_dir (lc[g]),
            .predict_gl_dir (gl[g]),
            .ghr_out        (gh[g]),
            .upd_valid      (upd_valid),
            .upd_opcode     (upd_opcode),
            .upd_pc         (upd_pc),
            .upd_taken      (upd_taken),
            .upd_pred_dir   (upd_pd[g]),
            .upd_lc_dir     (upd_lc[g]),
            .upd_gl_dir     (upd_gl[g]),
            .upd_ghr        (upd_gh[g]),
            .total_cnt      (tot[g]),
            .mispred_cnt    (mis[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall      = 1'b0;
        pc         = 32'h0;
        opcode     = 7'h0;
        upd_valid  = 1'b0;
        upd_opcode = 7'h0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        for (int m = 0; m < 3; m++) begin
            upd_pd[m] = 1'b0;
            upd_lc[m] = 1'b0;
            upd_gl[m] = 1'b0;
            upd_gh[m] = 5'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst = 1'b1;
        #1;
    endtask

    // One resolve cycle with the same recorded fields for every instance
    task automatic resolve(input logic [31:0] a, input logic [6:0] op, input logic t,
                           input logic p, input logic l, input logic g, input logic [4:0] h);
        opcode     = 7'h0;
        upd_valid  = 1'b1;
        upd_opcode = op;
        upd_pc     = a;
        upd_taken  = t;
        for (int m = 0; m < 3; m++) begin
            upd_pd[m] = p;
            upd_lc[m] = l;
            upd_gl[m] = g;
            upd_gh[m] = h;
        end
        step();
        upd_valid = 1'b0;
    endtask

    // Fetch a branch, then resolve it next cycle with what each instance recorded
    task automatic fetch_resolve(input logic [31:0] a, input logic t, output logic [2:0] p);
        pc     = a;
        opcode = OP_BR;
        #1;
        for (int m = 0; m < 3; m++) begin
            p[m]      = pd[m];
            upd_pd[m] = pd[m];
            upd_lc[m] = lc[m];
            upd_gl[m] = gl[m];
            upd_gh[m] = gh[m];
        end
        step();
        opcode     = 7'h0;
        upd_valid  = 1'b1;
        upd_opcode = OP_BR;
        upd_pc     = a;
        upd_taken  = t;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        pc     = 32'h40;
        opcode = OP_BR;
        #1;
        for (int m = 0; m < 3; m++) begin
            n_tests++; if (pd[m] !== 1'b0) begin n_fail++; $display("FAIL reset_pd mode%0d: got %0b expected 0", m, pd[m]); end
            n_tests++; if (lc[m] !== 1'b0) begin n_fail++; $display("FAIL reset_lc mode%0d: got %0b expected 0", m, lc[m]); end
            n_tests++; if (gl[m] !== 1'b0) begin n_fail++; $display("FAIL reset_gl mode%0d: got %0b expected 0", m, gl[m]); end
            n_tests++; if (gh[m] !== 5'd0) begin n_fail++; $display("FAIL reset_ghr mode%0d: got %0d expected 0", m, gh[m]); end
            n_tests++; if (tot[m] !== 32'd0) begin n_fail++; $display("FAIL reset_total mode%0d: got %0d expected 0", m, tot[m]); end
            n_tests++; if (mis[m] !== 32'd0) begin n_fail++; $display("FAIL reset_mispred mode%0d: got %0d expected 0", m, mis[m]); end
        end
        // Mispredicted taken branch at 0x40 with recorded history 00001
        resolve(32'h40, OP_BR, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00001);
        for (int m = 0; m < 3; m++) begin
            n_tests++; if (gh[m] !== 5'b00011) begin n_fail++; $display("FAIL pre_rst_ghr mode%0d: got %b expected 00011", m, gh[m]); end
            n_tests++; if (mis[m] !== 32'd1) begin n_fail++; $display("FAIL pre_rst_mispred mode%0d: got %0d expected 1", m, mis[m]); end
        end
        // Asynchronous reset between clock edges
        #2;
        rst    = 1'b0;
        pc     = 32'h40;
        opcode = OP_BR;
        #1;
        for (int m = 0; m < 3; m++) begin
            n_tests++; if (gh[m] !== 5'd0) begin n_fail++; $display("FAIL async_rst_ghr mode%0d: got %0d expected 0", m, gh[m]); end
            n_tests++; if (tot[m] !== 32'd0) begin n_fail++; $display("FAIL async_rst_total mode%0d: got %0d expected 0", m, tot[m]); end
            n_tests++; if (mis[m] !== 32'd0) begin n_fail++; $display("FAIL async_rst_mispred mode%0d: got %0d expected 0", m, mis[m]); end
        end
        n_tests++; if (pd[0] !== 1'b0) begin n_fail++; $display("FAIL async_rst_table: got %0b expected 0", pd[0]); end
        step();
        rst    = 1'b1;
        opcode = 7'h0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            resolve(32'h40, OP_BR, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
            pc = 32'h40; opcode = OP_BR; #1;
            n_tests++; if (pd[0] !== 1'b1) begin n_fail++; $display("FAIL sat_taken_%0d: got %0b expected 1", k, pd[0]); end
        end
        opcode = OP_ALU; #1;
        n_tests++; if (pd[0] !== 1'b0) begin n_fail++; $display("FAIL non_branch_mode0: got %0b expected 0", pd[0]); end
        n_tests++; if (pd[2] !== 1'b0) begin n_fail++; $display("FAIL non_branch_mode2: got %0b expected 0", pd[2]); end
        resolve(32'h40, OP_BR, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        pc = 32'h40; opcode = OP_BR; #1;
        n_tests++; if (pd[0] !== 1'b1) begin n_fail++; $display("FAIL sat_nt1: got %0b expected 1", pd[0]); end
        n_tests++; if (gl[1] !== 1'b1) begin n_fail++; $display("FAIL sat_nt1_gl: got %0b expected 1", gl[1]); end
        resolve(32'h40, OP_BR, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        pc = 32'h40; opcode = OP_BR; #1;
        n_tests++; if (pd[0] !== 1'b0) begin n_fail++; $display("FAIL sat_nt2: got %0b expected 0", pd[0]); end
        n_tests++; if (tot[0] !== 32'd6) begin n_fail++; $display("FAIL sat_total: got %0d expected 6", tot[0]); end
        opcode = 7'h0;
    endtask

    task automatic test_gshare();
        logic [2:0] p;
        logic       t;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            t = ((i % 2) == 0);
            fetch_resolve(32'h80, t, p);
            if (i >= 12) begin
                n_tests++; if (p[1] !== t) begin n_fail++; $display("FAIL gshare_pred_%0d: got %0b expected %0b", i, p[1], t); end
            end
        end
        n_tests++; if (mis[1] !== 32'd3) begin n_fail++; $display("FAIL gshare_mispred: got %0d expected 3", mis[1]); end
        n_tests++; if (mis[0] !== 32'd20) begin n_fail++; $display("FAIL local_alt_mispred: got %0d expected 20", mis[0]); end
        n_tests++; if (tot[0] !== 32'd20) begin n_fail++; $display("FAIL local_alt_total: got %0d expected 20", tot[0]); end
    endtask

    task automatic test_tournament();
        do_reset();
        // Local wrong, gshare right: chooser moves toward gshare
        resolve(32'h100, OP_BR, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0);
        resolve(32'h100, OP_BR, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0);
        // Pull local down; gshare updates land on index 1, not 0
        resolve(32'h100, OP_BR, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00001);
        resolve(32'h100, OP_BR, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00001);
        pc = 32'h100; opcode = OP_BR; #1;
        n_tests++; if (pd[2] !== 1'b1) begin n_fail++; $display("FAIL chooser_pd: got %0b expected 1", pd[2]); end
        n_tests++; if (lc[2] !== 1'b0) begin n_fail++; $display("FAIL chooser_lc: got %0b expected 0", lc[2]); end
        n_tests++; if (gl[2] !== 1'b1) begin n_fail++; $display("FAIL chooser_gl: got %0b expected 1", gl[2]); end
        n_tests++; if (pd[0] !== 1'b0) begin n_fail++; $display("FAIL chooser_mode0: got %0b expected 0", pd[0]); end
        n_tests++; if (pd[1] !== 1'b1) begin n_fail++; $display("FAIL chooser_mode1: got %0b expected 1", pd[1]); end
        // Agreeing components: chooser must not move
        resolve(32'h100, OP_BR, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00010);
        resolve(32'h100, OP_BR, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00010);
        pc = 32'h100; opcode = OP_BR; #1;
        n_tests++; if (pd[2] !== 1'b1) begin n_fail++; $display("FAIL chooser_hold: got %0b expected 1", pd[2]); end
        opcode = 7'h0;
    endtask

    task automatic test_restore();
        do_reset();
        pc         = 32'h40;
        opcode     = OP_BR;
        upd_valid  = 1'b1;
        upd_opcode = OP_BR;
        upd_pc     = 32'h200;
        upd_taken  = 1'b1;
        for (int m = 0; m < 3; m++) begin
            upd_pd[m] = 1'b0; upd_lc[m] = 1'b0; upd_gl[m] = 1'b0; upd_gh[m] = 5'b10110;
        end
        step();
        upd_valid = 1'b0;
        for (int m = 0; m < 3; m++) begin
            n_tests++; if (gh[m] !== 5'b01101) begin n_fail++; $display("FAIL restore_ghr mode%0d: got %b expected 01101", m, gh[m]); end
            n_tests++; if (pd[m] !== 1'b0) begin n_fail++; $display("FAIL restore_pd mode%0d: got %0b expected 0", m, pd[m]); end
        end
        step();
        for (int m = 0; m < 3; m++) begin
            n_tests++; if (gh[m] !== 5'b11010) begin n_fail++; $display("FAIL spec_shift_ghr mode%0d: got %b expected 11010", m, gh[m]); end
        end
        opcode = 7'h0;
    endtask

    task automatic test_stall_jump();
        do_reset();
        stall      = 1'b1;
        pc         = 32'h40;
        opcode     = OP_BR;
        upd_valid  = 1'b1;
        upd_opcode = OP_BR;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        for (int m = 0; m < 3; m++) begin
            upd_pd[m] = 1'b0; upd_lc[m] = 1'b0; upd_gl[m] = 1'b0; upd_gh[m] = 5'b00111;
        end
        repeat (2) step();
        for (int m = 0; m < 3; m++) begin
            n_tests++; if (gh[m] !== 5'd0) begin n_fail++; $display("FAIL stall_ghr mode%0d: got %b expected 00000", m, gh[m]); end
            n_tests++; if (tot[m] !== 32'd0) begin n_fail++; $display("FAIL stall_total mode%0d: got %0d expected 0", m, tot[m]); end
        end
        n_tests++; if (mis[2] !== 32'd0) begin n_fail++; $display("FAIL stall_mispred: got %0d expected 0", mis[2]); end
        stall     = 1'b0;
        upd_valid = 1'b0;
        #1;
        n_tests++; if (pd[0] !== 1'b0) begin n_fail++; $display("FAIL stall_table: got %0b expected 0", pd[0]); end
        opcode = OP_JAL; #1;
        for (int m = 0; m < 3; m++) begin
            n_tests++; if (pd[m] !== 1'b1) begin n_fail++; $display("FAIL jal_pd mode%0d: got %0b expected 1", m, pd[m]); end
        end
        step();
        n_tests++; if (gh[1] !== 5'd0) begin n_fail++; $display("FAIL jal_no_shift: got %b expected 00000", gh[1]); end
        opcode = OP_JALR; #1;
        n_tests++; if (pd[2] !== 1'b1) begin n_fail++; $display("FAIL jalr_pd: got %0b expected 1", pd[2]); end
        resolve(32'h40, OP_JAL, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        n_tests++; if (tot[0] !== 32'd1) begin n_fail++; $display("FAIL jal_total: got %0d expected 1", tot[0]); end
        n_tests++; if (mis[0] !== 32'd0) begin n_fail++; $display("FAIL jal_mispred: got %0d expected 0", mis[0]); end
        resolve(32'h40, OP_JALR, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11111);
        n_tests++; if (tot[1] !== 32'd2) begin n_fail++; $display("FAIL jalr_total: got %0d expected 2", tot[1]); end
        n_tests++; if (mis[1] !== 32'd1) begin n_fail++; $display("FAIL jalr_mispred: got %0d expected 1", mis[1]); end
        n_tests++; if (gh[1] !== 5'd0) begin n_fail++; $display("FAIL jalr_no_restore: got %b expected 00000", gh[1]); end
        pc = 32'h40; opcode = OP_BR; #1;
        n_tests++; if (pd[0] !== 1'b0) begin n_fail++; $display("FAIL jump_no_train_lc: got %0b expected 0", pd[0]); end
        n_tests++; if (gl[1] !== 1'b0) begin n_fail++; $display("FAIL jump_no_train_gl: got %0b expected 0", gl[1]); end
        opcode = 7'h0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_saturation();
        test_gshare();
        test_tournament();
        test_restore();
        test_stall_jump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
